// File: rtl/div_iter_pkg.sv
// Shared types and encodings for the iterative RV32M divider.
// Optional feature macro: DIV_REM_FUSE_EN (reuse of the last DIV/REM pair).
`ifndef DIV_ITER_DEFS
`define DIV_ITER_DEFS
`ifndef RV_XLEN
`define RV_XLEN 32
`endif
`define RV_DIVOP_RANGE 1:0
`define RV_DIVOP_DIV 2'd0
`define RV_DIVOP_DIVU 2'd1
`define RV_DIVOP_REM 2'd2
`define RV_DIVOP_REMU 2'd3
`define RV_DIVST_IDLE 2'd0
`define RV_DIVST_SPECIAL 2'd1
`define RV_DIVST_CALC 2'd2
`define RV_DIVST_DONE 2'd3
`endif

package div_iter_pkg;

    typedef logic [`RV_DIVOP_RANGE] divop_t;

    typedef enum logic [1:0] {
        ST_IDLE    = `RV_DIVST_IDLE,
        ST_SPECIAL = `RV_DIVST_SPECIAL,
        ST_CALC    = `RV_DIVST_CALC,
        ST_DONE    = `RV_DIVST_DONE
    } div_state_e;

    localparam divop_t OP_DIV  = `RV_DIVOP_DIV;
    localparam divop_t OP_DIVU = `RV_DIVOP_DIVU;
    localparam divop_t OP_REM  = `RV_DIVOP_REM;
    localparam divop_t OP_REMU = `RV_DIVOP_REMU;

    function automatic logic op_signed(divop_t op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_rem(divop_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response handshake bundle between execute stage and divider.
// master = pipeline side, slave = divider side.
interface div_iter_if #(
    parameter int XLEN = `RV_XLEN
);
    import div_iter_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [XLEN-1:0] req_dividend_i;
    logic [XLEN-1:0] req_divisor_i;
    divop_t          req_opcode_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_result_o;

    modport master (
        output req_valid_i, req_dividend_i, req_divisor_i, req_opcode_i,
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_result_o
    );

    modport slave (
        input  req_valid_i, req_dividend_i, req_divisor_i, req_opcode_i,
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_result_o
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_nx,
    output logic [XLEN-1:0] quo_nx
);
    logic [XLEN:0]   shl;
    logic [XLEN+1:0] diff;
    logic            borrow;
    logic            unused_msb;

    // shifted remainder needs XLEN+1 bits when divisor has its MSB set
    assign shl        = {rem, quo[XLEN-1]};
    assign diff       = {1'b0, shl} - {2'b00, divisor};
    assign borrow     = diff[XLEN+1];
    assign unused_msb = diff[XLEN];

    assign rem_nx = borrow ? shl[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_nx = {quo[XLEN-2:0], ~borrow};
endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// DIV_REM_FUSE_EN: keep last quotient+remainder to answer the paired op fast.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int XLEN  = `RV_XLEN,
    parameter int CNT_W = 6
) (
    input  logic      clk_i,
    input  logic      resetb_i,
    input  logic      clk_en_i,
    input  logic      kill_i,
    div_iter_if.slave bus
);
    div_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dsr_q, res_q;
    logic            vld_q, rdy_q;
    logic            rem_op_q, neg_q_q, neg_r_q;

    logic [XLEN-1:0] a, b, a_mag, b_mag;
    logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix;
    logic [XLEN-1:0] spec_res, fuse_res;
    logic            op_sgn, op_rem, a_neg, b_neg;
    logic            div0, ovf, fuse_hit, is_spc;
    logic            acc, calc_fin;

    assign a      = bus.req_dividend_i;
    assign b      = bus.req_divisor_i;
    assign op_sgn = op_signed(bus.req_opcode_i);
    assign op_rem = op_is_rem(bus.req_opcode_i);
    assign a_neg  = op_sgn & a[XLEN-1];
    assign b_neg  = op_sgn & b[XLEN-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign div0   = (b == '0);
    assign ovf    = op_sgn & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    assign is_spc = div0 | ovf | fuse_hit;

    assign acc      = (state_q == ST_IDLE) & bus.req_valid_i & ~kill_i;
    assign calc_fin = (state_q == ST_CALC) & (cnt_q == CNT_W'(XLEN)) & ~kill_i;

    assign q_fix = neg_q_q ? -quo_q : quo_q;
    assign r_fix = neg_r_q ? -rem_q : rem_q;

    always_comb begin
        spec_res = '0;
        unique case (1'b1)
            div0:    spec_res = op_rem ? a : '1;
            ovf:     spec_res = op_rem ? '0 : a;
            default: spec_res = fuse_res;
        endcase
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem     (rem_q),
        .quo     (quo_q),
        .divisor (dsr_q),
        .rem_nx  (rem_nx),
        .quo_nx  (quo_nx)
    );

`ifdef DIV_REM_FUSE_EN
    logic            ret_vld, ret_sgn, ret_rem;
    logic [XLEN-1:0] ret_a, ret_b, ret_q, ret_r;

    assign fuse_hit = ret_vld & (a == ret_a) & (b == ret_b)
                    & (op_sgn == ret_sgn) & (op_rem != ret_rem);
    assign fuse_res = op_rem ? ret_r : ret_q;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            ret_vld <= 1'b0;
            ret_sgn <= 1'b0;
            ret_rem <= 1'b0;
            ret_a   <= '0;
            ret_b   <= '0;
            ret_q   <= '0;
            ret_r   <= '0;
        end else if (clk_en_i) begin
            if (kill_i) begin
                ret_vld <= 1'b0;
            end else if (acc && (div0 || ovf)) begin
                ret_vld <= 1'b0;
            end else if (acc && fuse_hit) begin
                ret_rem <= op_rem;
            end else if (acc) begin
                // operands tracked from acceptance; valid only once finished
                ret_vld <= 1'b0;
                ret_a   <= a;
                ret_b   <= b;
                ret_sgn <= op_sgn;
                ret_rem <= op_rem;
            end else if (calc_fin) begin
                ret_vld <= 1'b1;
                ret_q   <= q_fix;
                ret_r   <= r_fix;
            end
        end
    end
`else
    assign fuse_hit = 1'b0;
    assign fuse_res = '0;
`endif

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            res_q    <= '0;
            vld_q    <= 1'b0;
            rdy_q    <= 1'b1;
            rem_op_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else if (clk_en_i) begin
            if (kill_i) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                vld_q   <= 1'b0;
                rdy_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.req_valid_i) begin
                            rem_op_q <= op_rem;
                            neg_q_q  <= a_neg ^ b_neg;
                            neg_r_q  <= a_neg;
                            rem_q    <= '0;
                            dsr_q    <= b_mag;
                            cnt_q    <= '0;
                            rdy_q    <= 1'b0;
                            quo_q    <= is_spc ? spec_res : a_mag;
                            state_q  <= is_spc ? ST_SPECIAL : ST_CALC;
                        end
                    end
                    ST_SPECIAL: begin
                        if (cnt_q == '0) begin
                            res_q <= quo_q;
                            cnt_q <= CNT_W'(1);
                        end else begin
                            vld_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_CALC: begin
                        if (cnt_q == CNT_W'(XLEN)) begin
                            res_q   <= rem_op_q ? r_fix : q_fix;
                            vld_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            rem_q <= rem_nx;
                            quo_q <= quo_nx;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        if (bus.rsp_ready_i) begin
                            vld_q   <= 1'b0;
                            rdy_q   <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.req_ready_o  = rdy_q;
    assign bus.rsp_valid_o  = vld_q;
    assign bus.rsp_result_o = res_q;
endmodule

// File: tb/tb_div_iter.sv
// Directed-vector bench for div_iter: results, latency, stall, freeze, kill.
// Paired-op latency follows DIV_REM_FUSE_EN.
module tb_div_iter;
    import div_iter_pkg::*;

`ifdef DIV_REM_FUSE_EN
    localparam int FLAT = 2;
`else
    localparam int FLAT = 33;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cen = 1'b1;
    logic kill = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    div_iter_if #(.XLEN(32)) bus ();

    div_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk),
        .resetb_i (rstn),
        .clk_en_i (cen),
        .kill_i   (kill),
        .bus      (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input divop_t op, input logic [31:0] a,
                         input logic [31:0] b);
        chk("req_ready", {31'd0, bus.req_ready_o}, 32'd1);
        bus.req_opcode_i   = op;
        bus.req_dividend_i = a;
        bus.req_divisor_i  = b;
        bus.req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.rsp_valid_o) break;
        end
        if (!bus.rsp_valid_o) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic run(input string tag, input divop_t op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        start(op, a, b);
        wait_rsp(lat);
        chk({tag, "_res"}, bus.rsp_result_o, exp);
        chk({tag, "_lat"}, lat, exp_lat);
        ack();
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] held;

        bus.req_valid_i    = 1'b0;
        bus.req_opcode_i   = OP_DIV;
        bus.req_dividend_i = '0;
        bus.req_divisor_i  = '0;
        bus.rsp_ready_i    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        chk("rst_result", bus.rsp_result_o, 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        run("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, FLAT);
        run("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, FLAT);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 2);
        run("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        run("divu_z", OP_DIVU, 32'd1234, 32'd0, 32'hFFFF_FFFF, 2);
        run("remu_z", OP_REMU, 32'd1234, 32'd0, 32'd1234, 2);
        run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);

        // backpressure: result must hold while consumer stalls
        start(OP_DIVU, 32'd50, 32'd5);
        wait_rsp(lat);
        held = bus.rsp_result_o;
        chk("bp_res", held, 32'd10);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold", bus.rsp_result_o, held);
            chk("bp_noready", {31'd0, bus.req_ready_o}, 32'd0);
            chk("bp_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
        end
        ack();
        chk("bp_idle", {31'd0, bus.req_ready_o}, 32'd1);

        // clock-enable freeze of three cycles during CALC
        start(OP_DIVU, 32'd1000, 32'd10);
        repeat (5) @(posedge clk);
        #1;
        cen = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cen = 1'b1;
        wait_rsp(lat);
        chk("frz_lat", lat + 8, 36);
        chk("frz_res", bus.rsp_result_o, 32'd100);
        ack();

        // kill at CALC iteration 10
        start(OP_DIVU, 32'hFFFF_FFFF, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_ready", {31'd0, bus.req_ready_o}, 32'd1);
        chk("kill_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid_o) pulses++;
        end
        chk("kill_nopulse", pulses, 0);

        run("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
        run("remu_9_3", OP_REMU, 32'd9, 32'd3, 32'd0, FLAT);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
